// File: rtl/r16_mod_cfg_ctrl.sv
// Modulus (N) reconfiguration controller for the radix-16 butterfly pipe and its N pipe.
// Optional macro R16_CFG_SKIP_SAME_EN: a request for the already-active N acks without draining.
module r16_mod_cfg_ctrl #(
  parameter int unsigned        P_WIDTH = 64,
  parameter logic [P_WIDTH-1:0] P_ZERO  = '0,
  parameter int unsigned        P_DEPTH = 4,
  parameter int unsigned        P_CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_req,
  input  logic [P_WIDTH-1:0] cfg_N,
  output logic               cfg_ack,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] N_out,
  output logic               N_load,
  output logic               busy
);

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    LOAD,
    SETTLE,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [P_DEPTH-1:0]   vld_sr;
  logic [P_CNT_W-1:0]   cnt;
  logic [P_CNT_W-1:0]   cnt_nx;
  logic [P_WIDTH-1:0]   shadow;
  logic                 accept;
  logic                 same_n;

  assign in_ready  = (state == RUN) & ~rst;
  assign busy      = (state != RUN);
  assign out_valid = vld_sr[P_DEPTH-1];
  assign accept    = in_valid & in_ready;

`ifdef R16_CFG_SKIP_SAME_EN
  assign same_n = (cfg_N == N_out);
`else
  assign same_n = 1'b0;
`endif

  // DRAIN exits only once the registered valid chain is empty, so N never changes under live data
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      RUN: begin
        if (cfg_req) state_nx = same_n ? DONE : DRAIN;
      end
      DRAIN: begin
        if (vld_sr == '0) state_nx = LOAD;
      end
      LOAD: begin
        state_nx = SETTLE;
        cnt_nx   = '0;
      end
      SETTLE: begin
        if (cnt == P_CNT_W'(P_DEPTH - 1)) state_nx = DONE;
        else                              cnt_nx   = cnt + P_CNT_W'(1);
      end
      DONE: begin
        state_nx = RUN;
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      vld_sr  <= '0;
      shadow  <= P_ZERO;
      N_out   <= P_ZERO;
      N_load  <= 1'b0;
      cfg_ack <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      vld_sr  <= P_DEPTH'({vld_sr, accept});
      if (state == RUN && cfg_req) shadow <= cfg_N;
      if (state == LOAD) N_out <= shadow;
      N_load  <= (state == LOAD);
      // registered so the ack pulse lines up exactly with the DONE cycle
      cfg_ack <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_r16_mod_cfg_ctrl.sv
// Self-checking bench for r16_mod_cfg_ctrl: directed scenarios plus randomized traffic,
// compared each cycle against a cycle-indexed behavioural model (honours R16_CFG_SKIP_SAME_EN).
module tb_r16_mod_cfg_ctrl;

  localparam int D     = 4;
  localparam int W     = 64;
  localparam int MAXC  = 8192;
  localparam int MAXP  = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_req = 1'b0;
  logic [W-1:0] cfg_N = '0;
  logic         cfg_ack;
  logic         in_valid = 1'b1;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] N_out;
  logic         N_load;
  logic         busy;

  r16_mod_cfg_ctrl #(
    .P_WIDTH(W),
    .P_ZERO (64'h0),
    .P_DEPTH(D),
    .P_CNT_W(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_req  (cfg_req),
    .cfg_N    (cfg_N),
    .cfg_ack  (cfg_ack),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .N_out    (N_out),
    .N_load   (N_load),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: timeline of accepted beats plus the cycle numbers at which
  // the pending request loads N and acknowledges, derived from drain/settle durations.
  bit           acc [0:MAXC-1];
  bit           m_pend = 1'b0;
  int           m_load = -1;
  int           m_ack = -1;
  int           m_nload = -1;
  int           m_last_acc = -1000;
  int           m_rst_mark = 0;
  logic [W-1:0] m_N = '0;
  logic [W-1:0] m_newN = '0;
  int           t_now;
  int           drain_end;
  bit           m_ready;
  bit           skip_same;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend     = 1'b0;
      m_N        = '0;
      m_nload    = -1;
      m_last_acc = -1000;
      m_rst_mark = cyc;
    end else begin
      t_now   = cyc;
      m_ready = !m_pend;
      if (in_valid && m_ready && t_now < MAXC) begin
        acc[t_now] = 1'b1;
        m_last_acc = t_now;
      end
      if (m_pend && t_now == m_load) begin
        m_N     = m_newN;
        m_nload = t_now + 1;
      end
      if (m_pend && t_now == m_ack) m_pend = 1'b0;
      if (m_ready && cfg_req) begin
        m_pend = 1'b1;
`ifdef R16_CFG_SKIP_SAME_EN
        skip_same = (cfg_N == m_N);
`else
        skip_same = 1'b0;
`endif
        if (skip_same) begin
          m_load = -1;
          m_ack  = t_now + 1;
        end else begin
          drain_end = (t_now + 1 > m_last_acc + D + 1) ? t_now + 1 : m_last_acc + D + 1;
          m_load    = drain_end + 1;
          m_ack     = m_load + D + 1;
          m_newN    = cfg_N;
        end
      end
    end
  end

  // Pinned literal checks are queued by the stimulus and evaluated by the compare process.
  string        pin_name [0:MAXP-1];
  logic [W-1:0] pin_act  [0:MAXP-1];
  logic [W-1:0] pin_exp  [0:MAXP-1];
  int           pin_seq = 0;
  int           pin_done = 0;

  int total = 0;
  int bad = 0;

  int ov_count = 0;
  int ov_rise_cyc = -1;
  int ov_last_cyc = -1;
  int ack_count = 0;
  int ack_last_cyc = -1;
  int nload_count = 0;
  int nload_last_cyc = -1;
  bit prev_ov = 1'b0;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic exp_ov;
    exp_ov = (cyc - D > m_rst_mark) && (cyc - D >= 0) && (cyc - D < MAXC) && acc[cyc-D];
    checkOutput("in_ready",  64'(in_ready),  64'(!rst && !m_pend));
    checkOutput("busy",      64'(busy),      64'(m_pend));
    checkOutput("out_valid", 64'(out_valid), 64'(exp_ov));
    checkOutput("cfg_ack",   64'(cfg_ack),   64'(m_pend && cyc == m_ack));
    checkOutput("N_load",    64'(N_load),    64'(cyc == m_nload));
    checkOutput("N_out",     N_out,          m_N);
    if (out_valid) begin
      ov_count++;
      ov_last_cyc = cyc;
      if (!prev_ov) ov_rise_cyc = cyc;
    end
    prev_ov = out_valid;
    if (cfg_ack) begin
      ack_count++;
      ack_last_cyc = cyc;
    end
    if (N_load) begin
      nload_count++;
      nload_last_cyc = cyc;
    end
    while (pin_done < pin_seq) begin
      checkOutput(pin_name[pin_done], pin_act[pin_done], pin_exp[pin_done]);
      pin_done++;
    end
  end

  task automatic pin(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    if (pin_seq < MAXP) begin
      pin_name[pin_seq] = name;
      pin_act[pin_seq]  = act;
      pin_exp[pin_seq]  = exp;
      pin_seq++;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic iv, input logic rq, input logic [W-1:0] n);
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = iv;
    cfg_req  = rq;
    cfg_N    = n;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Requester side of the handshake: hold cfg_req until ack is seen, drop it the next cycle.
  task automatic do_config(input logic [W-1:0] n, input logic first_valid, output int s_cyc);
    bit got;
    got = 1'b0;
    applyStimulus(1'b0, first_valid, 1'b1, n);
    s_cyc = cyc;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (cfg_ack) got = 1'b1;
      else         applyStimulus(1'b0, 1'b0, 1'b1, n);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, n);
    pin("cfg_ack_seen", 64'(got), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a0, s, snap_ov, snap_ack, snap_nl;
    bit req_act, first;
    int hold_rst;
    logic [W-1:0] rn;
    logic r, iv;

    // Reset held with in_valid high
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    @(negedge clk);
    pin("rst_N_out", N_out, 64'h0);
    pin("rst_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    pin("post_rst_in_ready", 64'(in_ready), 64'd1);
    idle(2);

    // Streaming: six consecutive beats
    snap_ov = ov_count;
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    a0 = cyc;
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    idle(8);
    pin("stream_beats", 64'(ov_count - snap_ov), 64'd6);
    pin("stream_latency", 64'(ov_rise_cyc - a0), 64'd4);

    // Config with an empty pipe
    snap_nl  = nload_count;
    do_config(64'hFFFFFFFF00000001, 1'b0, s);
    idle(3);
    pin("cfg3_N_out", N_out, 64'hFFFFFFFF00000001);
    pin("cfg3_nload", 64'(nload_count - snap_nl), 64'd1);
    pin("cfg3_ack_lat", 64'(ack_last_cyc - s), 64'd7);

    // Config arriving with the 4th beat of a burst
    snap_ov = ov_count;
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    do_config(64'h00000000DEADBEEF, 1'b1, s);
    idle(4);
    pin("cfg4_beats", 64'(ov_count - snap_ov), 64'd4);
    pin("cfg4_beats_before_load", 64'(ov_last_cyc < nload_last_cyc), 64'd1);
    pin("cfg4_ack_lat", 64'(ack_last_cyc - s), 64'd11);
    pin("cfg4_N_out", N_out, 64'h00000000DEADBEEF);

    // Reset during SETTLE aborts the request
    snap_ack = ack_count;
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b1, 64'h5555AAAA5555AAAA);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    idle(10);
    pin("abort_N_out", N_out, 64'h0);
    pin("abort_no_ack", 64'(ack_count - snap_ack), 64'd0);
    do_config(64'h0123456789ABCDEF, 1'b0, s);
    idle(2);
    pin("after_abort_N_out", N_out, 64'h0123456789ABCDEF);

    // Request for the value already in use
    snap_nl = nload_count;
    do_config(64'h0123456789ABCDEF, 1'b0, s);
    idle(3);
`ifdef R16_CFG_SKIP_SAME_EN
    pin("same_ack_lat", 64'(ack_last_cyc - s), 64'd1);
    pin("same_nload", 64'(nload_count - snap_nl), 64'd0);
`else
    pin("same_ack_lat", 64'(ack_last_cyc - s), 64'd7);
    pin("same_nload", 64'(nload_count - snap_nl), 64'd1);
`endif
    pin("same_N_out", N_out, 64'h0123456789ABCDEF);

    // Randomized traffic, requests, cfg_N jitter after capture, and occasional resets
    req_act  = 1'b0;
    first    = 1'b0;
    hold_rst = 0;
    rn       = '0;
    for (int i = 0; i < 1500; i++) begin
      r = 1'b0;
      if (hold_rst > 0) begin
        r = 1'b1;
        hold_rst--;
      end else if ($urandom_range(0, 199) == 0) begin
        r        = 1'b1;
        hold_rst = $urandom_range(0, 2);
        req_act  = 1'b0;
      end
      if (r) begin
        req_act = 1'b0;
      end else if (!req_act && $urandom_range(0, 29) == 0) begin
        req_act = 1'b1;
        first   = 1'b1;
        rn      = ($urandom_range(0, 2) == 0) ? m_N : {$urandom, $urandom};
      end else if (req_act && !first && $urandom_range(0, 3) == 0) begin
        rn = {$urandom, $urandom};
      end else begin
        first = 1'b0;
      end
      iv = ($urandom_range(0, 2) != 0);
      applyStimulus(r, iv, req_act, rn);
      first = 1'b0;
      @(negedge clk);
      if (req_act && cfg_ack) req_act = 1'b0;
    end

    idle(12);
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
